led_pattern_sequencer: RTL and testbench



---
 rtl/led_seq_pkg.sv | 30 +++
 rtl/led_pattern_sequencer_step_prescaler.sv | 32 +++
 rtl/led_pattern_sequencer.sv | 109 ++++++++++
 tb/tb_led_pattern_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - mode enumeration and per-mode entry patterns for the LED sequencer
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF       = 2'd0,
    MODE_CHASE     = 2'd1,
    MODE_BOUNCE    = 2'd2,
    MODE_BLINK_ALL = 2'd3
  } mode_t;

  // Patterns are written {LED_4, LED_3, LED_2, LED_1}
  localparam logic [3:0] ENTRY_OFF       = 4'b0000;
  localparam logic [3:0] ENTRY_CHASE     = 4'b0001;
  localparam logic [3:0] ENTRY_BOUNCE    = 4'b0001;
  localparam logic [3:0] ENTRY_BLINK_ALL = 4'b1111;

  function automatic logic [3:0] entry_pattern(input mode_t m);
    logic [3:0] p;
    p = ENTRY_OFF;
    case (m)
      MODE_OFF:       p = ENTRY_OFF;
      MODE_CHASE:     p = ENTRY_CHASE;
      MODE_BOUNCE:    p = ENTRY_BOUNCE;
      MODE_BLINK_ALL: p = ENTRY_BLINK_ALL;
      default:        p = ENTRY_OFF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_step_prescaler.sv
// rtl/led_pattern_sequencer_step_prescaler.sv - shared step prescaler, one-cycle tick at terminal count
module step_prescaler #(
  parameter int g_CLKS_PER_STEP = 2500000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Enable,
  input  logic i_Clear,
  output logic o_Tick
);

  localparam int W = $clog2(g_CLKS_PER_STEP);
  localparam logic [31:0] TERM = 32'(g_CLKS_PER_STEP - 1);

  logic [W-1:0] count;
  logic         at_term;

  // Compare at 32 bits so a non-power-of-two terminal count is never truncated
  assign at_term = (32'(count) == TERM);
  assign o_Tick  = i_Enable && !i_Clear && at_term;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      count <= '0;
    end else if (i_Clear) begin
      count <= '0;
    end else if (i_Enable) begin
      count <= at_term ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - mode register and pattern FSM driving four LEDs from one prescaler
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int g_CLKS_PER_STEP = 2500000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Mode_Next,
  input  logic       i_Pause,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4,
  output logic [1:0] o_Mode,
  output logic       o_Step
);

  mode_t      mode, mode_n;
  logic [3:0] leds, leds_n;
  logic [1:0] pos, pos_n;
  logic       dir_down, dir_down_n;
  logic       blink, blink_n;
  logic       step, step_n;
  logic       tick;

  // A mode advance clears the prescaler, which also suppresses a coincident tick
  step_prescaler #(
    .g_CLKS_PER_STEP(g_CLKS_PER_STEP)
  ) u_prescaler (
    .i_Clk    (i_Clk),
    .i_Rst_L  (i_Rst_L),
    .i_Enable (!i_Pause),
    .i_Clear  (i_Mode_Next),
    .o_Tick   (tick)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      mode     <= MODE_OFF;
      leds     <= ENTRY_OFF;
      pos      <= 2'd0;
      dir_down <= 1'b0;
      blink    <= 1'b0;
      step     <= 1'b0;
    end else begin
      mode     <= mode_n;
      leds     <= leds_n;
      pos      <= pos_n;
      dir_down <= dir_down_n;
      blink    <= blink_n;
      step     <= step_n;
    end
  end

  always_comb begin
    mode_n     = mode;
    leds_n     = leds;
    pos_n      = pos;
    dir_down_n = dir_down;
    blink_n    = blink;
    step_n     = 1'b0;
    if (i_Mode_Next) begin
      mode_n     = mode_t'(mode + 2'd1);
      leds_n     = entry_pattern(mode_n);
      pos_n      = 2'd0;
      dir_down_n = 1'b0;
      blink_n    = (mode_n == MODE_BLINK_ALL);
    end else if (tick) begin
      step_n = 1'b1;
      case (mode)
        MODE_OFF: leds_n = ENTRY_OFF;
        MODE_CHASE: leds_n = {leds[2:0], leds[3]};
        MODE_BOUNCE: begin
          // Turn around at the ends so each endpoint is shown exactly once
          if (!dir_down) begin
            if (pos == 2'd3) begin
              dir_down_n = 1'b1;
              pos_n      = 2'd2;
            end else begin
              pos_n = pos + 2'd1;
            end
          end else begin
            if (pos == 2'd0) begin
              dir_down_n = 1'b0;
              pos_n      = 2'd1;
            end else begin
              pos_n = pos - 2'd1;
            end
          end
          leds_n = 4'b0001 << pos_n;
        end
        MODE_BLINK_ALL: begin
          blink_n = !blink;
          leds_n  = {4{!blink}};
        end
        default: leds_n = ENTRY_OFF;
      endcase
    end
  end

  assign o_Mode  = mode;
  assign o_Step  = step;
  assign o_LED_1 = leds[0];
  assign o_LED_2 = leds[1];
  assign o_LED_3 = leds[2];
  assign o_LED_4 = leds[3];

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - scoreboard bench for led_pattern_sequencer with a 4-cycle step
module tb_led_pattern_sequencer;

  typedef struct {
    int         cyc;
    logic [1:0] mode;
    logic [3:0] leds;
    logic       step;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_next = 1'b0;
  logic       pause = 1'b0;
  logic       led_1, led_2, led_3, led_4;
  logic [1:0] mode;
  logic       step;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic mon_en = 1'b0;
  exp_t q[$];
  exp_t mon_e;
  logic [1:0] prev_mode = 2'd0;
  logic [3:0] prev_leds = 4'd0;
  logic [3:0] cur_leds;

  led_pattern_sequencer #(
    .g_CLKS_PER_STEP(4)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_Mode_Next (mode_next),
    .i_Pause     (pause),
    .o_LED_1     (led_1),
    .o_LED_2     (led_2),
    .o_LED_3     (led_3),
    .o_LED_4     (led_4),
    .o_Mode      (mode),
    .o_Step      (step)
  );

  always #5 clk = !clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: an output event is any o_Step pulse or a change of mode/LEDs
  always @(negedge clk) begin
    cur_leds = {led_4, led_3, led_2, led_1};
    if (mon_en && (step || mode != prev_mode || cur_leds != prev_leds)) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event cyc=%0d got mode=%0d leds=%b step=%b, required no event",
                 cyc, mode, cur_leds, step);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.cyc != cyc || mon_e.mode != mode || mon_e.leds != cur_leds || mon_e.step != step) begin
          miscompares++;
          $display("FAIL event got cyc=%0d mode=%0d leds=%b step=%b, required cyc=%0d mode=%0d leds=%b step=%b",
                   cyc, mode, cur_leds, step, mon_e.cyc, mon_e.mode, mon_e.leds, mon_e.step);
        end
      end
    end
    prev_mode = mode;
    prev_leds = cur_leds;
  end

  task automatic push(input int c, input logic [1:0] m, input logic [3:0] l, input logic s);
    exp_t e;
    e.cyc  = c;
    e.mode = m;
    e.leds = l;
    e.step = s;
    q.push_back(e);
  endtask

  task automatic step_to(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic advance(input logic [1:0] m, input logic [3:0] l);
    push(cyc + 1, m, l, 1'b0);
    mode_next = 1'b1;
    step_to(1);
    mode_next = 1'b0;
  endtask

  task automatic check_idle(input string name);
    vectors++;
    if ({mode, led_4, led_3, led_2, led_1, step} != 7'd0) begin
      miscompares++;
      $display("FAIL %s got mode=%0d leds=%b step=%b, required mode=0 leds=0000 step=0",
               name, mode, {led_4, led_3, led_2, led_1}, step);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d with %0d events outstanding", cyc, q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int r, a, b, c, e;
    logic [3:0] chase_pat [5];
    logic [3:0] bounce_pat [8];
    chase_pat  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    bounce_pat = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};

    step_to(2);
    check_idle("reset_state");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    r = cyc;
    for (int k = 1; k <= 3; k++) push(r + 4 * k, 2'd0, 4'b0000, 1'b1);
    step_to(13);

    a = cyc + 1;
    advance(2'd1, 4'b0001);
    for (int k = 0; k < 5; k++) push(a + 4 * (k + 1), 2'd1, chase_pat[k], 1'b1);
    step_to(21);

    b = cyc + 1;
    advance(2'd2, 4'b0001);
    for (int k = 0; k < 8; k++) push(b + 4 * (k + 1), 2'd2, bounce_pat[k], 1'b1);
    step_to(33);

    // BLINK_ALL: pause at count 2 for 10 edges, then a mode advance on terminal count
    c = cyc + 1;
    advance(2'd3, 4'b1111);
    push(c + 4, 2'd3, 4'b0000, 1'b1);
    step_to(6);
    pause = 1'b1;
    step_to(10);
    pause = 1'b0;
    push(c + 18, 2'd3, 4'b1111, 1'b1);
    push(c + 22, 2'd3, 4'b0000, 1'b1);
    step_to(9);
    advance(2'd0, 4'b0000);
    push(c + 30, 2'd0, 4'b0000, 1'b1);
    step_to(5);

    // Asynchronous reset between edges while CHASE shows 0100
    e = cyc + 1;
    advance(2'd1, 4'b0001);
    push(e + 4, 2'd1, 4'b0010, 1'b1);
    push(e + 8, 2'd1, 4'b0100, 1'b1);
    step_to(9);
    push(e + 9, 2'd0, 4'b0000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    step_to(3);
    rst_n = 1'b1;
    r = cyc;
    push(r + 4, 2'd0, 4'b0000, 1'b1);
    push(r + 8, 2'd0, 4'b0000, 1'b1);
    step_to(9);

    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_events got %0d outstanding, required 0 (next cyc=%0d)", q.size(), q[0].cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
